// File: rtl/cam_pkg.sv
// Shared camera package: row count, default sample width and the output FSM
// state encoding used by the camera pipeline blocks.
package cam_pkg;

    localparam int ROWS      = 2;
    localparam int CAM_ADC_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } out_state_t;

endpackage

// File: rtl/pixel_readout_capture_if.sv
// Pixel stream bus between the readout capture block and the downstream
// image-processing stage: one pixel per valid/ready beat with frame markers.
interface pixel_readout_capture_if #(
    parameter int ADC_W = cam_pkg::CAM_ADC_W
);

    logic             valid;
    logic             ready;
    logic [ADC_W-1:0] data;
    logic             sof;
    logic             last;

    modport master (output valid, data, sof, last, input ready);
    modport slave  (input valid, data, sof, last, output ready);

endinterface

// File: rtl/cam_edge_detect.sv
// Rising-edge detector for strobes that are already synchronous to clk; the
// history register resets to RESET_VAL so an input idling high cannot fire.
module cam_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            q <= din;
        end
    end

    assign rise = din & ~q;

endmodule

// File: rtl/pixel_readout_capture.sv
// Captures per-row ADC conversions driven by camera_controller, commits whole
// frames on erase rise and streams them out one pixel per beat.
// Optional FRAME_SUM_EN adds a per-frame pixel sum output.
module pixel_readout_capture
    import cam_pkg::*;
#(
    parameter int ADC_W = CAM_ADC_W,
    parameter int COLS  = 2,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    nre_1,
    input  logic                    nre_2,
    input  logic                    adc,
    input  logic                    expose,
    input  logic                    erase,
    input  logic [COLS*ADC_W-1:0]   adc_data,
    pixel_readout_capture_if.master m,
    output logic                    frame_dropped,
    output logic                    frame_incomplete,
    output logic                    protocol_err,
    output logic [CNT_W-1:0]        drop_count
`ifdef FRAME_SUM_EN
    ,
    output logic [ADC_W+$clog2(ROWS*COLS):0] frame_sum,
    output logic                             frame_sum_valid
`endif
);

    localparam int NPIX  = ROWS * COLS;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int ROW_W = COLS * ADC_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    logic adc_rise;
    logic expose_rise;
    logic erase_rise;

    cam_edge_detect #(.RESET_VAL(1'b0)) u_adc_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (adc),
        .rise (adc_rise)
    );

    cam_edge_detect #(.RESET_VAL(1'b0)) u_expose_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (expose),
        .rise (expose_rise)
    );

    // erase idles high between frames, so its history starts high
    cam_edge_detect #(.RESET_VAL(1'b1)) u_erase_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (erase),
        .rise (erase_rise)
    );

    logic                  cap_row0;
    logic                  cap_row1;
    logic                  both_rows_selected;
    logic [ROWS-1:0]       mask;
    logic [NPIX*ADC_W-1:0] cap_buf;
    logic [NPIX*ADC_W-1:0] out_buf;

    assign cap_row0           = adc_rise & ~nre_1 &  nre_2;
    assign cap_row1           = adc_rise &  nre_1 & ~nre_2;
    assign both_rows_selected = adc_rise & ~nre_1 & ~nre_2;

    // A capture in the same cycle as an expose rise belongs to the new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            mask    <= '0;
            cap_buf <= '0;
        end else begin
            if (expose_rise) begin
                mask <= '0;
            end
            if (cap_row0) begin
                cap_buf[0 +: ROW_W] <= adc_data;
                mask[0]             <= 1'b1;
            end
            if (cap_row1) begin
                cap_buf[ROW_W +: ROW_W] <= adc_data;
                mask[1]                 <= 1'b1;
            end
        end
    end

    out_state_t       state;
    out_state_t       state_d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;
    logic             beat;
    logic             last_beat;
    logic             mask_full;
    logic             buf_free;
    logic             commit;
    logic             drop;
    logic             incomplete;

    assign mask_full  = (mask == 2'b11);
    assign beat       = (state == STREAM) & m.ready;
    assign last_beat  = beat & (idx == LAST_IDX);
    assign buf_free   = (state == IDLE) | last_beat;
    assign commit     = erase_rise &  mask_full &  buf_free;
    assign drop       = erase_rise &  mask_full & ~buf_free;
    assign incomplete = erase_rise & ~mask_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        m.valid = 1'b0;
        m.data  = '0;
        m.sof   = 1'b0;
        m.last  = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                m.valid = 1'b1;
                m.data  = out_buf[int'(idx)*ADC_W +: ADC_W];
                m.sof   = (idx == '0);
                m.last  = (idx == LAST_IDX);
                if (beat) begin
                    if (idx == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = commit ? STREAM : IDLE;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_buf          <= '0;
            frame_dropped    <= 1'b0;
            frame_incomplete <= 1'b0;
            protocol_err     <= 1'b0;
            drop_count       <= '0;
        end else begin
            if (commit) begin
                out_buf <= cap_buf;
            end
            frame_dropped    <= drop;
            frame_incomplete <= incomplete;
            protocol_err     <= both_rows_selected;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

`ifdef FRAME_SUM_EN
    localparam int SUM_W = ADC_W + $clog2(NPIX) + 1;

    logic [SUM_W-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NPIX; i++) begin
            sum_d = sum_d + SUM_W'(cap_buf[i*ADC_W +: ADC_W]);
        end
    end

    // Sum is taken from the capture buffer so it lines up with the first beat
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sum       <= '0;
            frame_sum_valid <= 1'b0;
        end else begin
            frame_sum_valid <= commit;
            if (commit) begin
                frame_sum <= sum_d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Scoreboard bench for pixel_readout_capture: a frame-level reference model
// predicts the pixel stream and status pulses; a negedge monitor checks them.
module tb_pixel_readout_capture;
    import cam_pkg::*;

    localparam int ADC_W = 8;
    localparam int COLS  = 2;
    localparam int CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  nre_1 = 1'b1;
    logic                  nre_2 = 1'b1;
    logic                  adc = 1'b0;
    logic                  expose = 1'b0;
    logic                  erase = 1'b1;
    logic [COLS*ADC_W-1:0] adc_data = '0;
    logic                  frame_dropped;
    logic                  frame_incomplete;
    logic                  protocol_err;
    logic [CNT_W-1:0]      drop_count;
`ifdef FRAME_SUM_EN
    logic [ADC_W+$clog2(ROWS*COLS):0] frame_sum;
    logic                             frame_sum_valid;
`endif

    pixel_readout_capture_if #(.ADC_W(ADC_W)) m ();

    pixel_readout_capture #(
        .ADC_W (ADC_W),
        .COLS  (COLS),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .nre_1            (nre_1),
        .nre_2            (nre_2),
        .adc              (adc),
        .expose           (expose),
        .erase            (erase),
        .adc_data         (adc_data),
        .m                (m.master),
        .frame_dropped    (frame_dropped),
        .frame_incomplete (frame_incomplete),
        .protocol_err     (protocol_err),
        .drop_count       (drop_count)
`ifdef FRAME_SUM_EN
        ,
        .frame_sum        (frame_sum),
        .frame_sum_valid  (frame_sum_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADC_W-1:0] data;
        logic             sof;
        logic             last;
    } beat_t;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    int    ready_mode = 0;
    int    pcnt = 0;
    logic [3:0] pat = 4'b1001;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always, never, random, or the 1,0,0,1 pattern
    initial begin
        m.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m.ready = 1'b1;
                1:       m.ready = 1'b0;
                2:       m.ready = 1'($urandom_range(0, 1));
                default: begin
                    m.ready = pat[pcnt % 4];
                    pcnt++;
                end
            endcase
        end
    end

    task automatic applyStimulus(input logic n1, input logic n2, input logic a, input logic ex,
                                 input logic er, input logic [COLS*ADC_W-1:0] d);
        @(posedge clk);
        #1;
        nre_1    = n1;
        nre_2    = n2;
        adc      = a;
        expose   = ex;
        erase    = er;
        adc_data = d;
    endtask

    task automatic startExposure();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic strobeRow(input int r, input logic [COLS*ADC_W-1:0] d);
        applyStimulus(r != 0, r == 0, 1'b1, 1'b0, 1'b0, d);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic strobeBoth(input logic [COLS*ADC_W-1:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic endReadout();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, erase, adc_data);
    endtask

    task automatic fullFrame(input logic [COLS*ADC_W-1:0] d0, input logic [COLS*ADC_W-1:0] d1);
        startExposure();
        strobeRow(0, d0);
        strobeRow(1, d1);
        endReadout();
    endtask

    // Reference model state: frame-level view of the sensor rows and buffers
    logic [ADC_W-1:0] mrow [ROWS][COLS];
    logic [ROWS-1:0]  mmask;
    int               mdrop;
    logic             prev_adc, prev_exp, prev_er;
    logic             exp_drop, exp_inc, exp_perr;
    logic             started = 1'b0;
    logic             after_rst = 1'b0;
`ifdef FRAME_SUM_EN
    int               msum;
    logic             exp_sv;
`endif

    always @(negedge clk) begin
        logic a_r, ex_r, er_r;
        if (started) begin
            checkOutput("m_valid", 32'(m.valid), 32'(exp_q.size() != 0));
            if (m.valid && exp_q.size() != 0) begin
                checkOutput("m_data", 32'(m.data), 32'(exp_q[0].data));
                checkOutput("m_sof", 32'(m.sof), 32'(exp_q[0].sof));
                checkOutput("m_last", 32'(m.last), 32'(exp_q[0].last));
            end
            checkOutput("frame_dropped", 32'(frame_dropped), 32'(exp_drop));
            checkOutput("frame_incomplete", 32'(frame_incomplete), 32'(exp_inc));
            checkOutput("protocol_err", 32'(protocol_err), 32'(exp_perr));
            checkOutput("drop_count", 32'(drop_count), 32'(mdrop));
            if (after_rst) begin
                checkOutput("m_data_reset", 32'(m.data), 32'd0);
                checkOutput("m_sof_reset", 32'(m.sof), 32'd0);
                checkOutput("m_last_reset", 32'(m.last), 32'd0);
            end
`ifdef FRAME_SUM_EN
            checkOutput("frame_sum_valid", 32'(frame_sum_valid), 32'(exp_sv));
            checkOutput("frame_sum", 32'(frame_sum), 32'(msum));
`endif
        end
        after_rst = rst;
        if (rst) begin
            started  = 1'b1;
            exp_q.delete();
            mmask    = '0;
            mdrop    = 0;
            prev_adc = 1'b0;
            prev_exp = 1'b0;
            prev_er  = 1'b1;
            exp_drop = 1'b0;
            exp_inc  = 1'b0;
            exp_perr = 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mrow[r][c] = '0;
`ifdef FRAME_SUM_EN
            msum   = 0;
            exp_sv = 1'b0;
`endif
        end else begin
            if (m.valid && m.ready && exp_q.size() != 0)
                void'(exp_q.pop_front());
            a_r      = adc & ~prev_adc;
            ex_r     = expose & ~prev_exp;
            er_r     = erase & ~prev_er;
            exp_perr = a_r & ~nre_1 & ~nre_2;
            exp_drop = 1'b0;
            exp_inc  = 1'b0;
`ifdef FRAME_SUM_EN
            exp_sv = 1'b0;
`endif
            if (er_r) begin
                if (mmask == '1) begin
                    if (exp_q.size() == 0) begin
`ifdef FRAME_SUM_EN
                        msum   = 0;
                        exp_sv = 1'b1;
`endif
                        for (int r = 0; r < ROWS; r++)
                            for (int c = 0; c < COLS; c++) begin
                                exp_q.push_back('{data: mrow[r][c], sof: (r == 0 && c == 0),
                                                  last: (r == ROWS-1 && c == COLS-1)});
`ifdef FRAME_SUM_EN
                                msum += int'(mrow[r][c]);
`endif
                            end
                    end else begin
                        exp_drop = 1'b1;
                        if (mdrop < (1 << CNT_W) - 1) mdrop++;
                    end
                end else begin
                    exp_inc = 1'b1;
                end
            end
            if (ex_r) mmask = '0;
            if (a_r && (nre_1 != nre_2)) begin
                for (int c = 0; c < COLS; c++)
                    mrow[nre_1 ? 1 : 0][c] = adc_data[c*ADC_W +: ADC_W];
                mmask[nre_1 ? 1 : 0] = 1'b1;
            end
            prev_adc = adc;
            prev_exp = expose;
            prev_er  = erase;
        end
    end

    initial begin
        logic found;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal frame with the documented data pattern
        ready_mode = 0;
        fullFrame(16'h1122, 16'h3344);
        idle(8);

        // Backpressure pattern 1,0,0,1
        ready_mode = 3;
        pcnt = 0;
        fullFrame(16'($urandom), 16'($urandom));
        idle(16);

        // Drops while the output is stalled, enough to saturate the counter
        ready_mode = 1;
        fullFrame(16'hA5C3, 16'h0FF0);
        idle(2);
        repeat ((1 << CNT_W) + 5) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        end
        ready_mode = 0;
        idle(10);

        // Incomplete frames: one row only, and expose between rows
        startExposure();
        strobeRow(0, 16'h5566);
        endReadout();
        idle(3);
        startExposure();
        strobeRow(0, 16'h7788);
        startExposure();
        strobeRow(1, 16'h99AA);
        endReadout();
        idle(3);

        // Both row selects low on a strobe
        startExposure();
        strobeBoth(16'hDEAD);
        endReadout();
        idle(3);

        // Commit lands exactly on the last handshake of the previous frame
        ready_mode = 1;
        fullFrame(16'h0102, 16'h0304);
        strobeRow(0, 16'hB1B2);
        strobeRow(1, 16'hB3B4);
        ready_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m.valid && m.last) begin
                erase = 1'b1;
                found = 1'b1;
            end
        end
        checkOutput("b2b_alignment", 32'(found), 32'd1);
        idle(10);

        // Randomized frames with random backpressure and occasional faults
        ready_mode = 2;
        repeat (30) begin
            if ($urandom_range(0, 3) != 0) startExposure();
            if ($urandom_range(0, 1) != 0) begin
                if ($urandom_range(0, 7) != 0) strobeRow(0, 16'($urandom));
                if ($urandom_range(0, 7) != 0) strobeRow(1, 16'($urandom));
            end else begin
                if ($urandom_range(0, 7) != 0) strobeRow(1, 16'($urandom));
                if ($urandom_range(0, 7) != 0) strobeRow(0, 16'($urandom));
            end
            if ($urandom_range(0, 7) == 0) strobeBoth(16'($urandom));
            idle($urandom_range(0, 6));
            endReadout();
            idle($urandom_range(0, 8));
        end

        // Reset in the middle of a stalled stream
        ready_mode = 1;
        fullFrame(16'h4242, 16'h2424);
        idle(3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        idle(5);
        fullFrame(16'h6789, 16'hABCD);

        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) found = 1'b1;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
